pc_fetch_stage: RTL
===================

Name: pc_fetch_stage

Overview:
- Program-counter stage sitting directly upstream of the datapath adder. It holds the PC and produces the next sequential PC.
- It computes branch and jump targets by driving the existing 32-bit ripple adder (z, cout, a, b, cin).
- It presents a valid/ready fetch address to the instruction-memory/decode consumer.
- It inserts a one-cycle bubble on every redirect.

Parameters:
- WIDTH, 32, datapath and PC width.
- RESET_PC, 32'h0000_0080, PC value loaded on reset. Must be word-aligned.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- stall  input  1  hazard hold; PC frozen while high.
- branch_taken  input  1  take PC-relative branch on this advance.
- branch_imm  input  WIDTH  sign-extended word offset.
- jump  input  1  take absolute jump on this advance. Has priority over branch_taken.
- jump_target  input  WIDTH  absolute target; bits [1:0] are forced to 0.
- out_ready  input  1  consumer accepts fetch address.
- pc  output  WIDTH  current fetch address.
- pc_plus4  output  WIDTH  pc+4, combinational from the sequential adder.
- fetch_valid  output  1  pc is a valid fetch address.
- pc_wrap  output  1  one-cycle pulse when a sequential advance carried out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, fetch_valid=0, pc_wrap=0, state=IDLE.
  - pc_plus4 follows pc, so it reads RESET_PC+4.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - Entered only by reset. fetch_valid=0.
  - Next rising edge after rst_n deasserts goes to RUN unconditionally. pc unchanged.
- RUN:
  - fetch_valid=1.
  - advance = out_ready & ~stall.
  - If ~advance: pc, state and outputs hold. fetch_valid stays 1 and pc stays stable (valid must not drop while not ready).
  - If advance, next pc is chosen by priority:
    - jump → {jump_target[WIDTH-1:2],2'b00}; go to FLUSH.
    - else branch_taken → pc_plus4 + (branch_imm<<2), computed by the target adder with cin=0, cout ignored; go to FLUSH.
    - else → pc_plus4; stay in RUN.
- FLUSH:
  - fetch_valid=0 for exactly one cycle; pc already holds the target.
  - jump, branch_taken, stall and out_ready are ignored.
  - Next edge goes to RUN.
- Redirect inputs are sampled only on an advancing edge. Asserting them while stalled, not ready, in IDLE, or in FLUSH has no effect.
- Arithmetic:
  - Sequential adder: a=pc, b=4, cin=0.
  - Target adder: a=pc_plus4, b=branch_imm<<2 (low 2 bits zero, top 2 bits of imm discarded), cin=0.
  - All results are modulo 2^WIDTH.
- Wrap-around: a sequential advance from 32'hFFFF_FFFC gives pc=0. pc_wrap=1 for the following cycle only. No wrap flag is raised for branch or jump targets.
- Reset mid-operation, in any state: immediate return to reset values. A pending redirect is lost.
- Simultaneous jump and branch_taken: jump wins.
- Simultaneous stall and redirect: hold; the redirect is dropped unless it is still asserted on the advancing edge.

Decomposition:
- Shared package (arch_pkg) holds:
  - WORD_BYTES=4
  - RESET_PC default
  - state encoding IDLE=2'd0, RUN=2'd1, FLUSH=2'd2
- Two instances of the existing yAdder: sequential increment and branch target.
- One natural sub-module: pc_next_mux. It is combinational, performs the priority selection and the target alignment, and keeps the FSM/register logic separate.

Test Plan:
- Reset release, out_ready=1, no stall/redirect:
  - cycle 0: fetch_valid=0, pc=0x80.
  - then fetch_valid=1 with pc 0x80, 0x84, 0x88 on consecutive cycles.
- At pc=0x88, stall=1 for 3 cycles, then out_ready=0 for 2 cycles:
  - pc stays 0x88 and fetch_valid stays 1 throughout.
  - advance resumes to 0x8C.
- At pc=0x90, branch_taken=1, branch_imm=32'hFFFF_FFFC (−4):
  - next pc = 0x94−16 = 0x84.
  - fetch_valid=0 for one cycle, then 1 with pc=0x84.
- At pc=0x100, jump=1 and branch_taken=1 together, jump_target=0x0000_2003:
  - pc=0x2000, one bubble cycle.
  - branch ignored; redirects asserted during the bubble ignored.
- pc forced via jump to 0xFFFF_FFFC, then sequential advance:
  - pc=0x0 and pc_wrap=1 for exactly one cycle.
- rst_n pulled low asynchronously mid-FLUSH (between edges):
  - pc=0x80 and fetch_valid=0 immediately.
  - IDLE→RUN sequence repeats after release.

Source files
------------

// File: rtl/arch_pkg.sv
// Shared definitions for the PC fetch stage: word size, reset PC and FSM encoding.
package arch_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0080;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: jump over branch over sequential; jump targets are word-aligned here.
module pc_next_mux #(
    parameter int WIDTH = 32
) (
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect
);

    logic unused;
    assign unused = ^jump_target[1:0];

    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        if (jump) begin
            next_pc  = {jump_target[WIDTH-1:2], 2'b00};
            redirect = 1'b1;
        end else if (branch_taken) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/yAdder.sv
// Ripple-carry adder used by the datapath; z = a + b + cin, cout is the carry out of the MSB.
module yAdder #(
    parameter int W = 32
) (
    output logic [W-1:0] z,
    output logic         cout,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign z[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/pc_fetch_stage.sv
// Program-counter stage: holds the PC, drives the sequential and branch-target adders,
// and offers the fetch address to the consumer with a one-cycle bubble after each redirect.
module pc_fetch_stage
    import arch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_imm,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             pc_wrap,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);

    // Handshake: pc is offered while fetch_valid=1 and taken on a rising edge where
    // out_ready=1 and stall=0; once offered, pc and fetch_valid hold until taken.
    state_t           state;
    logic             seq_cout;
    logic [WIDTH-1:0] branch_target;
    logic             tgt_cout;
    logic [WIDTH-1:0] next_pc;
    logic             redirect;
    logic             advance;
    logic             unused;

    assign unused    = ^{tgt_cout, branch_imm[WIDTH-1:WIDTH-2]};
    assign advance   = out_ready & ~stall;
    assign state_dbg = state;

    yAdder #(.W(WIDTH)) u_seq_adder (
        .z    (pc_plus4),
        .cout (seq_cout),
        .a    (pc),
        .b    (STEP),
        .cin  (1'b0)
    );

    yAdder #(.W(WIDTH)) u_tgt_adder (
        .z    (branch_target),
        .cout (tgt_cout),
        .a    (pc_plus4),
        .b    ({branch_imm[WIDTH-3:0], 2'b00}),
        .cin  (1'b0)
    );

    pc_next_mux #(.WIDTH(WIDTH)) u_next_mux (
        .jump          (jump),
        .branch_taken  (branch_taken),
        .jump_target   (jump_target),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            pc_wrap     <= 1'b0;
        end else begin
            pc_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        pc <= next_pc;
                        if (redirect) begin
                            state       <= FLUSH;
                            fetch_valid <= 1'b0;
                        end else begin
                            // Only sequential advances report carry-out as a wrap.
                            pc_wrap <= seq_cout;
                        end
                    end
                end
                FLUSH: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
